emulib_scanchain_ram: RTL and testbench

EMULIB_SCANCHAIN_RAM -- requirements
Module: emulib_scanchain_ram

---
 rtl/emulib_scanchain_ram.sv | 201 ++++++++++++++++++++
 tb/tb_emulib_scanchain_ram.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/emulib_scanchain_ram.sv
// Emulation RAM with a serial scan chain for loading and dumping its contents.
// The functional port gives a synchronous write and a registered read. The scan
// port streams the whole memory, word 0 first and each word LSB first, through
// a one-word shift register. The scan FSM reuses the functional read register
// to prefetch the next word while the current word is being shifted out.
module emulib_scanchain_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  host_clk,
  input  logic                  host_rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ram_sr,
  input  logic                  ram_se,
  input  logic                  ram_sd,
  input  logic                  ram_di,
  output logic                  ram_do
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int WW = $clog2(DEPTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [WW-1:0] WORD_END = WW'(DEPTH);
  localparam logic [AW:0]   ADDR_END = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    OUT_FILL,
    OUT_SHIFT,
    IN_SHIFT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]         word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  scan_rd;
  logic [AW-1:0]         scan_rd_addr;
  logic                  scan_wr;
  logic [AW-1:0]         scan_wr_addr;
  logic [DATA_WIDTH-1:0] scan_wr_data;

  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  func_ok;
  logic                  addr_ok;
  logic [WW-1:0]         word_next;
  logic [DATA_WIDTH-1:0] shift_in;

  // Any scan control activity owns the RAM for that cycle.
  assign func_ok   = en && !ram_sr && !ram_se;
  assign addr_ok   = ({1'b0, addr} < ADDR_END);
  assign word_next = word_cnt_q + 1'b1;
  assign shift_in  = {ram_di, shreg_q[DATA_WIDTH-1:1]};

  // Scan FSM: next state, counters, shift register and RAM requests.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    scan_rd      = 1'b0;
    scan_rd_addr = '0;
    scan_wr      = 1'b0;
    scan_wr_addr = '0;
    scan_wr_data = '0;

    if (ram_sr) begin
      state_d    = ARMED;
      shreg_d    = '0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (ram_se) begin
      case (state_q)
        ARMED: begin
          if (ram_sd) begin
            shreg_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = IN_SHIFT;
          end else begin
            scan_rd      = 1'b1;
            scan_rd_addr = '0;
            word_cnt_d   = WW'(1);
            state_d      = OUT_FILL;
          end
        end

        OUT_FILL: begin
          shreg_d      = rdata_q;
          scan_rd      = 1'b1;
          scan_rd_addr = word_cnt_q[AW-1:0];
          state_d      = OUT_SHIFT;
        end

        OUT_SHIFT: begin
          if (bit_cnt_q == BIT_LAST) begin
            shreg_d   = rdata_q;
            bit_cnt_d = '0;
            if (word_cnt_q == WORD_END) begin
              state_d = DONE;
            end else begin
              word_cnt_d = word_next;
              if (word_next < WORD_END) begin
                scan_rd      = 1'b1;
                scan_rd_addr = word_next[AW-1:0];
              end
            end
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        IN_SHIFT: begin
          shreg_d = shift_in;
          if (bit_cnt_q == BIT_LAST) begin
            scan_wr      = 1'b1;
            scan_wr_addr = word_cnt_q[AW-1:0];
            scan_wr_data = shift_in;
            bit_cnt_d    = '0;
            word_cnt_d   = word_next;
            if (word_next == WORD_END) begin
              state_d = DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        IDLE: ;
        DONE: ;
        default: ;
      endcase
    end
  end

  // RAM port arbitration between the scan engine and the functional port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    rdata_d   = rdata_q;

    if (scan_wr) begin
      mem_we    = 1'b1;
      mem_waddr = scan_wr_addr;
      mem_wdata = scan_wr_data;
    end else if (func_ok && we && addr_ok) begin
      mem_we    = 1'b1;
      mem_waddr = addr;
      mem_wdata = wdata;
    end

    if (scan_rd) begin
      rdata_d = mem[scan_rd_addr];
    end else if (func_ok && !we && addr_ok) begin
      rdata_d = mem[addr];
    end
  end

  // Control state and read register, cleared asynchronously by host reset.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage array keeps its contents through host reset.
  always_ff @(posedge host_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata  = rdata_q;
  assign ram_do = shreg_q[0];

endmodule

// File: tb/tb_emulib_scanchain_ram.sv
// Scoreboard bench for emulib_scanchain_ram (DATA_WIDTH=8, DEPTH=4).
// Stimulus pushes expected outputs tagged with the cycle they should appear in;
// a monitor at every falling edge pops due entries and compares them.
module tb_emulib_scanchain_ram;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AW = 2;

  logic          host_clk   = 1'b0;
  logic          host_rst_n = 1'b0;
  logic          en         = 1'b0;
  logic          we         = 1'b0;
  logic [AW-1:0] addr       = '0;
  logic [DW-1:0] wdata      = '0;
  logic [DW-1:0] rdata;
  logic          ram_sr     = 1'b0;
  logic          ram_se     = 1'b0;
  logic          ram_sd     = 1'b0;
  logic          ram_di     = 1'b0;
  logic          ram_do;

  emulib_scanchain_ram #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP)
  ) dut (
    .host_clk  (host_clk),
    .host_rst_n(host_rst_n),
    .en        (en),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ram_sr    (ram_sr),
    .ram_se    (ram_se),
    .ram_sd    (ram_sd),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 host_clk = ~host_clk;

  // Cycle number used to schedule expectations.
  int cyc = 0;
  always @(posedge host_clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         is_do;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_item;
  int   compared   = 0;
  int   mismatched = 0;

  logic [7:0] fn_words [4];
  logic [7:0] in_words [4];

  task automatic pushExp(input int at, input bit is_do, input logic [7:0] v, input string tag);
    exp_t e;
    e.at    = at;
    e.is_do = is_do;
    e.exp   = v;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    compared++;
    act = e.is_do ? {7'b0, ram_do} : rdata;
    if (e.at != cyc) begin
      mismatched++;
      $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", e.tag, cyc, e.at);
    end else if (act !== e.exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)", e.tag, act, e.exp, cyc);
    end
  endtask

  // Monitor: compare every expectation that has come due this cycle.
  always @(negedge host_clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_item = sb.pop_front();
      checkOutput(mon_item);
    end
  end

  task automatic step();
    @(posedge host_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s_en, input logic s_we, input logic [AW-1:0] s_addr,
                               input logic [DW-1:0] s_wdata, input logic s_sr, input logic s_se,
                               input logic s_sd, input logic s_di);
    en     = s_en;
    we     = s_we;
    addr   = s_addr;
    wdata  = s_wdata;
    ram_sr = s_sr;
    ram_se = s_se;
    ram_sd = s_sd;
    ram_di = s_di;
    step();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic funcWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic funcRead(input logic [AW-1:0] a, input logic [DW-1:0] e, input string tag);
    pushExp(cyc + 1, 1'b0, e, tag);
    applyStimulus(1'b1, 1'b0, a, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scanReset();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scanStep(input logic sd, input logic di);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, sd, di);
  endtask

  function automatic logic outBit(input int k);
    logic [7:0] w;
    w = fn_words[k / 8];
    return w[k % 8];
  endfunction

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    logic [7:0] tmp;
    int         gap;
    fn_words = '{8'h11, 8'h22, 8'h33, 8'h44};
    in_words = '{8'hA5, 8'h5A, 8'hFF, 8'h00};

    // Reset values while host reset is held.
    step();
    step();
    pushExp(cyc, 1'b0, 8'h00, "reset rdata");
    pushExp(cyc, 1'b1, 8'h00, "reset ram_do");
    step();
    host_rst_n = 1'b1;
    step();

    // Functional writes and reads.
    for (int i = 0; i < 4; i++) funcWrite(AW'(i), fn_words[i]);
    pushExp(cyc, 1'b0, 8'h00, "write keeps rdata");
    funcRead(2'd2, 8'h33, "read addr2");
    funcRead(2'd0, 8'h11, "read addr0");
    funcRead(2'd3, 8'h44, "read addr3");

    // Functional accesses are blocked while scan controls are active.
    applyStimulus(1'b1, 1'b1, 2'd1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    pushExp(cyc + 1, 1'b0, 8'h44, "read blocked by se");
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 8'hDD, 1'b1, 1'b0, 1'b0, 1'b0);
    funcRead(2'd1, 8'h22, "write blocked by se");
    funcRead(2'd2, 8'h33, "write blocked by sr");
    pushExp(cyc + 1, 1'b0, 8'h33, "read blocked by sr");
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Gap-free scan-out: two prefill cycles then 32 shifts.
    scanReset();
    scanStep(1'b0, 1'b0);
    scanStep(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      pushExp(cyc, 1'b1, {7'b0, outBit(i)}, $sformatf("scanout w%0d b%0d", i / 8, i % 8));
      scanStep(1'b0, 1'b0);
    end
    idleCycle();
    pushExp(cyc, 1'b0, 8'h44, "rdata after scanout");
    scanStep(1'b0, 1'b0);
    scanStep(1'b1, 1'b1);
    idleCycle();
    pushExp(cyc, 1'b0, 8'h44, "done ignores se");

    // Scan-out with random gaps and ram_sd wiggling after the scan has started.
    scanReset();
    for (int j = 0; j < 34; j++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if (j >= 2) pushExp(cyc, 1'b1, {7'b0, outBit(j - 2)}, $sformatf("gap hold b%0d", j - 2));
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      if (j >= 2) pushExp(cyc, 1'b1, {7'b0, outBit(j - 2)}, $sformatf("gap scanout b%0d", j - 2));
      scanStep((j == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
    end
    idleCycle();

    // Scan-in of four words plus one trailing ram_se.
    scanReset();
    for (int i = 0; i < 32; i++) begin
      tmp = in_words[i / 8];
      scanStep((i == 0) ? 1'b1 : 1'((i % 3) != 0), tmp[i % 8]);
    end
    scanStep(1'b1, 1'b1);
    pushExp(cyc, 1'b1, 8'h00, "done ram_do after extra se");
    idleCycle();
    for (int i = 0; i < 4; i++) funcRead(AW'(i), in_words[i], $sformatf("scanin word%0d", i));

    // Interrupted scan-in: 13 bits, then ram_sr together with ram_se.
    scanReset();
    tmp = 8'h3C;
    for (int i = 0; i < 8; i++) scanStep(1'b1, tmp[i]);
    tmp = 8'h0F;
    for (int i = 0; i < 5; i++) scanStep(1'b1, tmp[i]);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    idleCycle();
    funcRead(2'd0, 8'h3C, "partial word0 written");
    funcRead(2'd1, 8'h5A, "partial word1 untouched");
    tmp = 8'hC3;
    for (int i = 0; i < 8; i++) scanStep(1'b1, tmp[i]);
    idleCycle();
    funcRead(2'd0, 8'hC3, "fresh scan word0");
    funcRead(2'd1, 8'h5A, "fresh scan word1");

    // Host reset pulse between edges during OUT_SHIFT.
    scanReset();
    scanStep(1'b0, 1'b0);
    scanStep(1'b0, 1'b0);
    tmp = 8'hC3;
    for (int i = 0; i < 6; i++) begin
      pushExp(cyc, 1'b1, {7'b0, tmp[i]}, $sformatf("pre-reset b%0d", i));
      scanStep(1'b0, 1'b0);
    end
    pushExp(cyc, 1'b1, 8'h01, "pre-reset ram_do");
    pushExp(cyc, 1'b0, 8'h5A, "pre-reset rdata");
    @(negedge host_clk);
    #1;
    host_rst_n = 1'b0;
    #2;
    host_rst_n = 1'b1;
    pushExp(cyc + 1, 1'b1, 8'h00, "async reset ram_do");
    pushExp(cyc + 1, 1'b0, 8'h00, "async reset rdata");
    step();
    scanStep(1'b0, 1'b0);
    scanStep(1'b1, 1'b1);
    scanStep(1'b0, 1'b0);
    pushExp(cyc, 1'b1, 8'h00, "idle ignores se ram_do");
    pushExp(cyc, 1'b0, 8'h00, "idle ignores se rdata");
    idleCycle();
    funcRead(2'd0, 8'hC3, "mem intact word0");
    funcRead(2'd1, 8'h5A, "mem intact word1");
    funcRead(2'd2, 8'hFF, "mem intact word2");

    // Drain the scoreboard and report.
    idleCycle();
    repeat (3) step();
    while (sb.size() > 0) begin
      mon_item = sb.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: never checked, required cycle %0d", mon_item.tag, mon_item.at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
